// File: rtl/rr_stream_mux.sv
// Registered CH:1 valid/ready stream mux with fixed-select or round-robin arbitration.
// Optional even-parity output out_par is enabled by defining RR_MUX_PARITY_EN.
module rr_stream_mux #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    localparam int SW   = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    output logic [WIDTH-1:0]    out_data,
    output logic [SW-1:0]       out_ch,
    output logic                out_valid,
    input  logic                out_ready
`ifdef RR_MUX_PARITY_EN
    ,
    output logic                out_par
`endif
);

    logic [SW-1:0]    r_rr_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_ch;
    logic             r_out_valid;

    logic             w_load_en;
    logic             w_found;
    logic [SW-1:0]    w_idx;
    logic [CH-1:0]    w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin: scan from the farthest candidate back to rr_ptr+1 so the
    // nearest valid channel after rr_ptr overwrites the rest and wins.
    always_comb begin
        logic [SW-1:0] w_cand;
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        if (!mode) begin
            w_found = in_valid[sel];
            w_idx   = sel;
        end else begin
            for (int k = CH; k >= 1; k--) begin
                w_cand = r_rr_ptr + SW'(k);
                if (in_valid[w_cand]) begin
                    w_found = 1'b1;
                    w_idx   = w_cand;
                end
            end
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_grant
        assign w_grant[gi] = w_found && (w_idx == SW'(gi));
    end

    assign in_ready   = rst_n ? (w_grant & {CH{w_load_en}}) : '0;
    assign w_xfer     = rst_n && w_found && w_load_en;
    assign w_sel_data = in_data[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= SW'(CH - 1);
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_rr_ptr    <= w_idx;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_idx;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RR_MUX_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_par <= 1'b0;
        end else if (w_xfer) begin
            r_out_par <= ^w_sel_data;
        end
    end

    assign out_par = r_out_par;
`endif

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a per-cycle reference model predicts grants and
// queues expected words; a separate monitor compares every popped output word.
module tb_rr_stream_mux;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;
`ifdef RR_MUX_PARITY_EN
    logic            out_par;
`endif

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(W), .CH(CH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RR_MUX_PARITY_EN
        , .out_par(out_par)
`endif
    );

    typedef struct {
        logic [W-1:0] d;
        int           ch;
        logic         par;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_ptr    = CH - 1;
    bit   m_valid  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                              input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Reference model: applies the selection rules to the inputs of the current cycle.
    task automatic model_cycle();
        int            g;
        bit            load;
        logic [CH-1:0] exp_ready;
        exp_t          e;
        g = -1;
        load = 0;
        exp_ready = '0;
        if (rst_n) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (!mode) begin
                if (in_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 1; k <= CH; k++) begin
                    int c;
                    c = (m_ptr + k) % CH;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end
            load = !m_valid || out_ready;
            if (load && g >= 0) exp_ready[g] = 1'b1;
        end
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
        if (!rst_n) begin
            m_valid = 0;
            m_ptr   = CH - 1;
            q.delete();
        end else if (load && g >= 0) begin
            e.d   = in_data[g*W +: W];
            e.ch  = g;
            e.par = ^e.d;
            q.push_back(e);
            $display("xfer ch=%0d data=%04h mode=%0d", g, e.d, mode);
            m_ptr   = g;
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic md,
                        input logic [SW-1:0] s, input logic ordy, input logic rn);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        mode      = md;
        sel       = s;
        out_ready = ordy;
        rst_n     = rn;
        #1;
        model_cycle();
    endtask

    task automatic check_reset_state();
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
`ifdef RR_MUX_PARITY_EN
        chk("rst_out_par", {31'd0, out_par}, 32'd0);
`endif
    endtask

    // Monitor: a pop happens at the next edge whenever out_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    chk("pop_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    $display("pop ch=%0d data=%04h exp_ch=%0d exp_data=%04h", out_ch, out_data, e.ch, e.d);
                    chk("out_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("out_ch", {30'd0, out_ch}, 32'(e.ch));
`ifdef RR_MUX_PARITY_EN
                    chk("out_par", {31'd0, out_par}, {31'd0, e.par});
`endif
                end
            end
        end
    end

    initial begin
        logic [CH*W-1:0] rr_d;
        logic [CH*W-1:0] rd;
        logic            rmode;
        rst_n = 1'b0; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        rr_d = pack4(16'h1000, 16'h1001, 16'h1002, 16'h1003);

        step('0, '0, 0, 0, 1, 0);
        check_reset_state();

        // Fixed select, legacy 2:1 case
        step(4'b1111, pack4(16'h00AF, 16'h00FA, 16'h2222, 16'h3333), 0, 0, 1, 1);
        step(4'b1111, pack4(16'h00AF, 16'h00FA, 16'h2222, 16'h3333), 0, 1, 1, 1);
        step(4'b0000, '0, 0, 1, 1, 1);

        // Round-robin fairness
        for (int i = 0; i < 10; i++) step(4'b1111, rr_d, 1, 0, 1, 1);

        // Back-pressure then release
        for (int i = 0; i < 3; i++) step(4'b1111, rr_d, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(4'b1111, rr_d, 1, 0, 1, 1);
        step(4'b0000, '0, 1, 0, 1, 1);

        // Sparse round-robin and mode switch
        step(4'b0100, rr_d, 1, 0, 1, 1);
        step(4'b0101, rr_d, 1, 0, 1, 1);
        step(4'b0100, rr_d, 0, 2, 1, 1);
        step(4'b1111, rr_d, 1, 0, 1, 1);
        step(4'b0000, '0, 1, 0, 1, 1);

        // Reset while holding a word
        step(4'b0010, pack4(16'h0, 16'h00FA, 16'h0, 16'h0), 0, 1, 1, 1);
        step(4'b0000, '0, 0, 1, 0, 1);
        step(4'b0000, '0, 0, 1, 0, 0);
        check_reset_state();
        step(4'b1111, rr_d, 1, 0, 1, 1);
        step(4'b0000, '0, 1, 0, 1, 1);

        // Parity words
        step(4'b0001, pack4(16'h00AF, 16'h0, 16'h0, 16'h0), 0, 0, 1, 1);
        step(4'b0001, pack4(16'h0001, 16'h0, 16'h0, 16'h0), 0, 0, 1, 1);
        step(4'b0000, '0, 0, 0, 1, 1);

        // Random traffic with occasional reset and mode flips
        rmode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) rd[c*W +: W] = W'($urandom);
            if ($urandom_range(0, 15) == 0) rmode = ~rmode;
            step(CH'($urandom), rd, rmode, SW'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 199) != 0));
        end

        for (int i = 0; i < 3; i++) step(4'b0000, '0, 1, 0, 1, 1);
        @(negedge clk);
        #3;
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
